// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one fixed-latency memory port: data has priority,
// bounded by a fetch-starvation counter; read responses return in grant order.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [3:0]    d_be,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-3:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          stall
);
  localparam int SCW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

  logic [SCW-1:0]     starve_q, starve_d;
  logic [MEM_LAT-1:0] tag_v_q;
  logic [MEM_LAT-1:0] tag_o_q;
  logic               tag_v_d;
  logic               tag_o_d;
  logic               grant_if;
  logic               grant_d;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

  // Data normally wins; a fetch that has watched STARVE_MAX data grants goes first.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (d_req && !(if_req && starve_q == STARVE_LIM)) begin
      grant_d = 1'b1;
    end else if (if_req) begin
      grant_if = 1'b1;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!if_req || grant_if) begin
      starve_d = '0;
    end else if (grant_d && starve_q != STARVE_LIM) begin
      starve_d = starve_q + SCW'(1);
    end
  end

  // Tag owner: 1 = data port, 0 = fetch port. Stores carry no valid tag.
  assign tag_v_d = grant_if | (grant_d & ~d_we);
  assign tag_o_d = grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      tag_v_q  <= '0;
      tag_o_q  <= '0;
    end else begin
      starve_q   <= starve_d;
      tag_v_q[0] <= tag_v_d;
      tag_o_q[0] <= tag_o_d;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_o_q[i] <= tag_o_q[i-1];
      end
    end
  end

  // Every output is held at zero while reset is asserted, independent of inputs.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    stall     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = 32'h0;
    d_rdata   = 32'h0;
    if (rst_n) begin
      if_gnt = grant_if;
      d_gnt  = grant_d;
      mem_en = grant_if | grant_d;
      if (grant_d) begin
        mem_we    = d_we;
        mem_be    = d_we ? d_be : 4'hF;
        mem_addr  = d_addr[AW-1:2];
        mem_wdata = d_wdata;
      end else if (grant_if) begin
        mem_be   = 4'hF;
        mem_addr = if_addr[AW-1:2];
      end
      stall = (if_req & ~grant_if) | (d_req & ~grant_d);
      if (tag_v_q[MEM_LAT-1]) begin
        if (tag_o_q[MEM_LAT-1]) begin
          d_rvalid = 1'b1;
          d_rdata  = mem_rdata;
        end else begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Three arbiters (MEM_LAT 1..3) share one stimulus stream; a behavioural
// model of grants and in-order responses checks all of them every cycle.
module tb_mem_arbiter;
  localparam int AW   = 32;
  localparam int ND   = 3;
  localparam int SMAX = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          if_req  = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          d_req   = 1'b0;
  logic          d_we    = 1'b0;
  logic [AW-1:0] d_addr  = '0;
  logic [31:0]   d_wdata = '0;
  logic [3:0]    d_be    = '0;

  logic [ND-1:0] if_gnt_w, if_rvalid_w, d_gnt_w, d_rvalid_w, mem_en_w, mem_we_w, stall_w;
  logic [31:0]   if_rdata_w [ND];
  logic [31:0]   d_rdata_w [ND];
  logic [31:0]   mem_wdata_w [ND];
  logic [31:0]   mem_rdata_w [ND];
  logic [3:0]    mem_be_w [ND];
  logic [AW-3:0] mem_addr_w [ND];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] hash(input logic [AW-3:0] wa);
    logic [31:0] x;
    x = 32'(wa);
    return (x * 32'h9E3779B1) ^ 32'hC3A50F1E;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_dut
      logic [31:0] pipe [4];
      mem_arbiter #(.AW(AW), .MEM_LAT(gi + 1), .STARVE_MAX(SMAX)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_w[gi]),
        .if_rvalid(if_rvalid_w[gi]), .if_rdata(if_rdata_w[gi]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt_w[gi]), .d_rvalid(d_rvalid_w[gi]), .d_rdata(d_rdata_w[gi]),
        .mem_en(mem_en_w[gi]), .mem_we(mem_we_w[gi]), .mem_be(mem_be_w[gi]),
        .mem_addr(mem_addr_w[gi]), .mem_wdata(mem_wdata_w[gi]),
        .mem_rdata(mem_rdata_w[gi]), .stall(stall_w[gi])
      );
      // Memory model: read word is a hash of its address, garbage otherwise.
      always @(posedge clk) begin
        pipe[0] <= (mem_en_w[gi] && !mem_we_w[gi]) ? hash(mem_addr_w[gi]) : $urandom;
        for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
      end
      assign mem_rdata_w[gi] = pipe[gi];
    end
  endgenerate

  // Behavioural model: one grant record per cycle, response due LAT cycles later.
  int            starve = 0;
  bit            hv [8];
  bit            ho [8];
  logic [AW-3:0] ha [8];
  bit            m_egi, m_egd, m_ev, m_eo;
  logic [2:0]    m_idx;
  logic [31:0]   m_ed, m_ewd;
  logic [3:0]    m_ebe;
  logic [AW-3:0] m_eaddr;

  always @(negedge clk) begin
    m_egi = 1'b0;
    m_egd = 1'b0;
    if (rst_n) begin
      if (if_req && d_req) begin
        m_egi = (starve == SMAX);
        m_egd = !m_egi;
      end else begin
        m_egi = if_req;
        m_egd = d_req;
      end
    end
    m_ebe   = m_egd ? (d_we ? d_be : 4'hF) : (m_egi ? 4'hF : 4'h0);
    m_eaddr = m_egd ? d_addr[AW-1:2] : (m_egi ? if_addr[AW-1:2] : '0);
    m_ewd   = m_egd ? d_wdata : 32'h0;
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("if_gnt L%0d", k + 1), 64'(if_gnt_w[k]), 64'(m_egi));
      chk($sformatf("d_gnt L%0d", k + 1), 64'(d_gnt_w[k]), 64'(m_egd));
      chk($sformatf("mem_en L%0d", k + 1), 64'(mem_en_w[k]), 64'(m_egi | m_egd));
      chk($sformatf("stall L%0d", k + 1), 64'(stall_w[k]),
          64'(rst_n && ((if_req && !m_egi) || (d_req && !m_egd))));
      if (!rst_n || m_egi || m_egd) begin
        chk($sformatf("mem_we L%0d", k + 1), 64'(mem_we_w[k]), 64'(m_egd && d_we));
        chk($sformatf("mem_be L%0d", k + 1), 64'(mem_be_w[k]), 64'(m_ebe));
        chk($sformatf("mem_addr L%0d", k + 1), 64'(mem_addr_w[k]), 64'(m_eaddr));
        chk($sformatf("mem_wdata L%0d", k + 1), 64'(mem_wdata_w[k]), 64'(m_ewd));
      end
      m_idx = 3'(cyc - k - 1);
      m_ev  = rst_n && hv[m_idx];
      m_eo  = ho[m_idx];
      m_ed  = hash(ha[m_idx]);
      chk($sformatf("if_rvalid L%0d", k + 1), 64'(if_rvalid_w[k]), 64'(m_ev && !m_eo));
      chk($sformatf("d_rvalid L%0d", k + 1), 64'(d_rvalid_w[k]), 64'(m_ev && m_eo));
      if (m_ev || !rst_n) begin
        chk($sformatf("if_rdata L%0d", k + 1), 64'(if_rdata_w[k]), 64'((m_ev && !m_eo) ? m_ed : 32'h0));
        chk($sformatf("d_rdata L%0d", k + 1), 64'(d_rdata_w[k]), 64'((m_ev && m_eo) ? m_ed : 32'h0));
      end
    end
    if (!rst_n) begin
      starve = 0;
      for (int i = 0; i < 8; i++) hv[i] = 1'b0;
    end else begin
      m_idx     = 3'(cyc);
      hv[m_idx] = m_egi || (m_egd && !d_we);
      ho[m_idx] = m_egd;
      ha[m_idx] = m_eaddr;
      if (!if_req || m_egi) starve = 0;
      else if (m_egd && starve < SMAX) starve++;
      if (m_egi || m_egd)
        $display("cyc %0d grant %s we=%0d waddr=%h be=%h", cyc, m_egd ? "D" : "I",
                 m_egd && d_we, m_eaddr, m_ebe);
    end
  end

  task automatic chk_all_zero(input string tag);
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("%s gnt L%0d", tag, k + 1), 64'({if_gnt_w[k], d_gnt_w[k]}), 64'(0));
      chk($sformatf("%s mem L%0d", tag, k + 1),
          64'({mem_en_w[k], mem_we_w[k], mem_be_w[k], stall_w[k]}), 64'(0));
      chk($sformatf("%s maddr L%0d", tag, k + 1), 64'(mem_addr_w[k]), 64'(0));
      chk($sformatf("%s mwdata L%0d", tag, k + 1), 64'(mem_wdata_w[k]), 64'(0));
      chk($sformatf("%s rv L%0d", tag, k + 1), 64'({if_rvalid_w[k], d_rvalid_w[k]}), 64'(0));
      chk($sformatf("%s rdata L%0d", tag, k + 1), {if_rdata_w[k], d_rdata_w[k]}, 64'(0));
    end
  endtask

  task automatic rand_run(input int n);
    bit took_i, took_d;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      took_i = if_gnt_w[0];
      took_d = d_gnt_w[0];
      @(posedge clk); #1;
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      if (!if_req || took_i) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = $urandom;
      end else if ($urandom_range(0, 19) == 0) begin
        if_req = 1'b0;
      end
      if (!d_req || took_d) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = ($urandom_range(0, 2) == 0);
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_be    = 4'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        d_req = 1'b0;
      end
    end
  endtask

  initial begin
    string exp_seq;
    byte   got;
    int    nd;
    int    jj;

    // Reset with both requesters active: everything must read zero.
    repeat (2) @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    @(negedge clk);
    chk_all_zero("reset");

    // Simultaneous fetch and load right after reset release: data first.
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("both d_gnt", 64'(d_gnt_w[0]), 64'(1));
    chk("both if_gnt", 64'(if_gnt_w[0]), 64'(0));
    chk("both mem_addr", 64'(mem_addr_w[0]), 64'(32'h40));
    chk("both stall", 64'(stall_w[0]), 64'(1));
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    chk("both if_gnt2", 64'(if_gnt_w[0]), 64'(1));
    chk("both stall2", 64'(stall_w[0]), 64'(0));
    chk("both d_rvalid", 64'(d_rvalid_w[0]), 64'(1));
    chk("both d_rdata", 64'(d_rdata_w[0]), 64'(hash(30'h40)));
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    chk("both if_rvalid", 64'(if_rvalid_w[0]), 64'(1));
    chk("both if_rdata", 64'(if_rdata_w[0]), 64'(hash(30'h0)));

    // Back-to-back fetches 0x0, 0x4, 0x8.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if_req  = (i < 3);
      if_addr = 32'(4 * i);
      @(negedge clk);
      if (i < 3) begin
        chk("seq if_gnt", 64'(if_gnt_w[0]), 64'(1));
        chk("seq mem_addr", 64'(mem_addr_w[0]), 64'(i));
      end
      if (i > 0) begin
        chk("seq if_rvalid", 64'(if_rvalid_w[0]), 64'(1));
        chk("seq if_rdata", 64'(if_rdata_w[0]), 64'(hash(30'(i - 1))));
      end
    end

    // Starvation bound: fetch held, six data loads.
    exp_seq = "DDDDIDD";
    nd = 0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      got = d_gnt_w[0] ? "D" : (if_gnt_w[0] ? "I" : "-");
      chk($sformatf("starve seq %0d", j), 64'(got), 64'(exp_seq[j]));
      if (d_gnt_w[0]) nd++;
      @(posedge clk); #1;
      if (nd >= 6) d_req = 1'b0;
      d_addr = d_addr + 32'h4;
    end
    if_req = 1'b0; d_req = 1'b0;

    // Store with partial byte enables, then a store with no enables.
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h13; d_be = 4'b0110; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      chk("store mem_we", 64'(mem_we_w[k]), 64'(1));
      chk("store mem_addr", 64'(mem_addr_w[k]), 64'(4));
      chk("store mem_be", 64'(mem_be_w[k]), 64'(4'b0110));
      chk("store mem_wdata", 64'(mem_wdata_w[k]), 64'(32'hDEADBEEF));
    end
    @(posedge clk); #1;
    d_be = 4'h0; d_addr = 32'h20;
    @(negedge clk);
    chk("be0 mem_en", 64'(mem_en_w[0]), 64'(1));
    chk("be0 mem_be", 64'(mem_be_w[0]), 64'(0));
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("store no d_rvalid", 64'(d_rvalid_w), 64'(0));
    end

    // Alternating fetch/data loads, checked on the MEM_LAT=3 instance.
    for (int j = 0; j < 11; j++) begin
      @(posedge clk); #1;
      if (j < 8 && j % 2 == 0) begin
        if_req = 1'b1; d_req = 1'b0; if_addr = 32'(32'h200 + 8 * j);
      end else if (j < 8) begin
        if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'(32'h300 + 8 * j);
      end else begin
        if_req = 1'b0; d_req = 1'b0;
      end
      @(negedge clk);
      if (j >= 3) begin
        jj = j - 3;
        if (jj % 2 == 0) begin
          chk("alt if_rvalid", 64'(if_rvalid_w[2]), 64'(1));
          chk("alt if_rdata", 64'(if_rdata_w[2]), 64'(hash(30'((32'h200 + 8 * jj) >> 2))));
        end else begin
          chk("alt d_rvalid", 64'(d_rvalid_w[2]), 64'(1));
          chk("alt d_rdata", 64'(d_rdata_w[2]), 64'(hash(30'((32'h300 + 8 * jj) >> 2))));
        end
      end
    end

    // Reset one cycle after a read grant discards the read.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h44;
    @(negedge clk);
    chk("rst read granted", 64'(if_gnt_w[1]), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b0; d_req = 1'b1; d_we = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (2) @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0; rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post-rst rvalid", 64'({if_rvalid_w[1], d_rvalid_w[1]}), 64'(0));
    end

    rand_run(900);
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    repeat (6) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32, byte-address width of both requester ports.
REQ-002 Parameter MEM_LAT, default 1, fixed read latency of the shared memory in cycles; legal range 1..4.
REQ-003 Parameter STARVE_MAX, default 4, maximum consecutive data grants while a fetch waits.
REQ-004 clk  in  1  system clock; all state updates on posedge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 if_req  in  1  instruction-fetch read request; held with if_addr until if_gnt.
REQ-007 if_addr  in  AW  fetch byte address.
REQ-008 if_gnt  out  1  fetch request accepted this cycle.
REQ-009 if_rvalid  out  1  if_rdata valid this cycle.
REQ-010 if_rdata  out  32  fetched word.
REQ-011 d_req  in  1  data request; held with d_we, d_addr, d_wdata, d_be until d_gnt.
REQ-012 d_we  in  1  1 = store, 0 = load.
REQ-013 d_addr  in  AW  data byte address.
REQ-014 d_wdata  in  32  store data.
REQ-015 d_be  in  4  store byte enables.
REQ-016 d_gnt  out  1  data request accepted this cycle.
REQ-017 d_rvalid  out  1  d_rdata valid this cycle (loads only).
REQ-018 d_rdata  out  32  load word.
REQ-019 mem_en  out  1  memory access strobe.
REQ-020 mem_we  out  1  memory write.
REQ-021 mem_be  out  4  memory byte enables.
REQ-022 mem_addr  out  AW-2  word address (selected addr[AW-1:2]).
REQ-023 mem_wdata  out  32  memory write data.
REQ-024 mem_rdata  in  32  read data, valid MEM_LAT cycles after mem_en with mem_we=0.
REQ-025 stall  out  1  a request is pending and not granted this cycle.

Function
REQ-026 At most one grant per cycle; a grant is possible every cycle (fully pipelined, no idle gap between accesses).
REQ-027 if_gnt, d_gnt, mem_en, mem_we, mem_be, mem_addr and mem_wdata are combinational from the current requests and registered arbitration state; mem_en equals if_gnt OR d_gnt.
REQ-028 Priority: data wins over fetch when both request, unless starve_cnt equals STARVE_MAX, in which case fetch wins.
REQ-029 starve_cnt (width ceil(log2(STARVE_MAX+1))) increments on each d_gnt while if_req is high, clears on if_gnt or when if_req is low, and saturates at STARVE_MAX.
REQ-030 On fetch grant: mem_we=0, mem_be=4'hF, mem_addr=if_addr[AW-1:2], mem_wdata=0.
REQ-031 On data grant: mem_we=d_we, mem_be=d_we ? d_be : 4'hF, mem_addr=d_addr[AW-1:2], mem_wdata=d_wdata; address bits [1:0] are ignored.
REQ-032 A MEM_LAT-deep tag shift register records, per cycle, {valid, owner}; valid is set only for read grants (fetch, or data with d_we=0).
REQ-033 When the tag emerging at depth MEM_LAT is valid, exactly one of if_rvalid/d_rvalid pulses for one cycle according to owner; the matching rdata equals mem_rdata; the non-selected rdata output is 0.
REQ-034 Stores generate no rvalid; a store is complete at its d_gnt cycle.
REQ-035 Responses return in grant order; no reordering.
REQ-036 stall = (if_req AND NOT if_gnt) OR (d_req AND NOT d_gnt).
REQ-037 A request dropped before grant is legal and produces no access.
REQ-038 d_be=4'h0 with d_we=1 is still granted and drives mem_en with mem_be=0.

Reset
REQ-039 While rst_n is low: starve_cnt=0, all tags invalid, and every output is 0 (grants, rvalids, rdatas, mem_* and stall forced low regardless of inputs).
REQ-040 Reset asserted with reads in flight discards them; no rvalid is produced for any read granted before reset.
REQ-041 First grant is possible in the first posedge after rst_n deasserts.

Verification
REQ-042 Fetch only, if_addr=0x0,0x4,0x8 on consecutive cycles, MEM_LAT=1 -> if_gnt three cycles, mem_addr 0,1,2, if_rvalid three cycles one cycle later with matching mem_rdata.
REQ-043 if_req and d_req (load, d_addr=0x100) same cycle -> d_gnt first, mem_addr=0x40, stall=1; if_gnt next cycle; rvalids in the same order.
REQ-044 if_req held, d_req held for 6 cycles, STARVE_MAX=4 -> grant sequence D,D,D,D,I,D,D.
REQ-045 Store d_addr=0x13, d_be=4'b0110, d_wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x4, mem_be=4'b0110; no d_rvalid.
REQ-046 MEM_LAT=3, alternating I/D loads every cycle -> rvalids alternate starting 3 cycles after first grant, data not swapped.
REQ-047 rst_n pulled low one cycle after a read grant with MEM_LAT=2 -> all outputs 0 immediately; no rvalid after release.
